expmul_pipe: RTL

EXPMUL_PIPE -- requirements
Module: expmul_pipe

---
 rtl/expmul_pipe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/expmul_pipe.sv
// Three-stage pipeline that scales a signed vector by about exp(a-b), using a power-of-two shift.
// Optional build macro: EXPMUL_PIPE_ROUND_EN selects round-half-up shifting instead of truncation.
module expmul_pipe #(
  parameter int VEC_LEN   = 64,
  parameter int DATA_W    = 8,
  parameter int SCORE_W   = 16,
  parameter int FRAC_BITS = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vld_in,
  output logic                        rdy_out,
  input  logic [SCORE_W-1:0]          a_in,
  input  logic [SCORE_W-1:0]          b_in,
  input  logic [VEC_LEN*DATA_W-1:0]   v_in,
  output logic                        vld_out,
  input  logic                        rdy_in,
  output logic [VEC_LEN*DATA_W-1:0]   v_out
);

  localparam int VW = VEC_LEN * DATA_W;
  localparam int DW = SCORE_W + 1;
  localparam int XW = SCORE_W + 3;
  localparam int LW = $clog2(DATA_W + 1);

  logic                 vld_p0, vld_p1, vld_p2;
  logic                 adv0, adv1, adv2;
  logic signed [DW-1:0] d_p0;
  logic [VW-1:0]        v_p0, v_p1, v_p2;
  logic [LW-1:0]        l_p1;
  logic [VW-1:0]        v_s3;

  // d is never positive, so the scale factor never exceeds 1.
  function automatic logic signed [DW-1:0] clamp_diff(input logic [SCORE_W-1:0] a,
                                                      input logic [SCORE_W-1:0] b);
    logic signed [DW-1:0] d;
    d = $signed({a[SCORE_W-1], a}) - $signed({b[SCORE_W-1], b});
    return (d > 0) ? '0 : d;
  endfunction

  // l ~ -x*log2(e), approximated as -(x + x/2 - x/16), saturated at DATA_W.
  function automatic logic [LW-1:0] shift_amt(input logic signed [DW-1:0] d);
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] l;
    x = XW'(d) >>> FRAC_BITS;
    l = -(x + (x >>> 1) - (x >>> 4));
    if (l >= XW'(DATA_W))
      return LW'(DATA_W);
    else if (l < 0)
      return '0;
    else
      return LW'(l);
  endfunction

  function automatic logic signed [DATA_W-1:0] lane_shift(input logic signed [DATA_W-1:0] v,
                                                          input logic [LW-1:0] l);
`ifdef EXPMUL_PIPE_ROUND_EN
    logic signed [DATA_W:0] t;
    logic signed [DATA_W:0] half;
`endif
    if (l >= LW'(DATA_W))
      return '0;
`ifdef EXPMUL_PIPE_ROUND_EN
    if (l == '0)
      return v;
    half = '0;
    half[l - LW'(1)] = 1'b1;
    t = {v[DATA_W-1], v};
    t = t + half;
    return DATA_W'(t >>> l);
`else
    return v >>> l;
`endif
  endfunction

  assign adv2    = rdy_in | ~vld_p2;
  assign adv1    = adv2 | ~vld_p1;
  assign adv0    = adv1 | ~vld_p0;
  assign rdy_out = adv0 | rst;
  assign vld_out = vld_p2;
  assign v_out   = v_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv0) vld_p0 <= vld_in;
      if (adv1) vld_p1 <= vld_p0;
      if (adv2) vld_p2 <= vld_p1;
    end
  end

  // S1: score difference and vector capture
  always_ff @(posedge clk) begin
    if (adv0 && vld_in) begin
      d_p0 <= clamp_diff(a_in, b_in);
      v_p0 <= v_in;
    end
  end

  // S2: shift amount
  always_ff @(posedge clk) begin
    if (adv1 && vld_p0) begin
      l_p1 <= shift_amt(d_p0);
      v_p1 <= v_p0;
    end
  end

  always_comb begin
    v_s3 = '0;
    for (int i = 0; i < VEC_LEN; i++)
      v_s3[i*DATA_W +: DATA_W] = lane_shift(v_p1[i*DATA_W +: DATA_W], l_p1);
  end

  // S3: scaled vector; output data is cleared by reset so no stale vector is visible
  always_ff @(posedge clk) begin
    if (rst)
      v_p2 <= '0;
    else if (adv2 && vld_p1)
      v_p2 <= v_s3;
  end

endmodule
